// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner for the MIPS fetch stage.
//
// Picks the next pc each cycle from pc_plus4 (external incrementer), branch
// and jump targets, a buffered redirect, or the exception vector. It holds
// pc on stall, buffers redirects that arrive while stalled, and sequences
// BOOT -> RUN, RUN <-> HALT and exception entry. flush is a registered pulse
// that is high in the cycle pc first shows a redirected value.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   pc_plus4              pc + 4 from the incrementer
//   stall                 hazard stall, pc holds
//   branch_taken/_target  resolved taken branch and its destination
//   jump/jump_target      jump request and its destination
//   exception             exception request
//   halt / resume         enter / leave HALT
//   pc                    registered program counter
//   fetch_valid           fetch at pc is valid this cycle
//   flush                 one-cycle pulse to the IF/ID registers
//   epc                   pc captured at exception entry
//   redirect_pending      a buffered redirect waits for stall release
//   state                 00 BOOT, 01 RUN, 10 HALT (debug/observability)
//
// Handshake: fetch_valid is a plain qualifier with no ready; the consumer
// takes the fetch at pc in every cycle fetch_valid is high.

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  input  logic        halt,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic [31:0] epc,
  output logic        redirect_pending,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_jump_q, pend_jump_d;   // buffered redirect is a jump
  logic [31:0] pend_target_q, pend_target_d;

  logic        misaligned;
  logic        drain_pending;
  logic        take_exc;

  // Only the redirect that would be selected this cycle is checked for
  // alignment: an aligned jump masks a simultaneous misaligned branch.
  assign misaligned = (jump && (jump_target[1:0] != 2'b00)) ||
                      (!jump && branch_taken && (branch_target[1:0] != 2'b00));

  // On the stall-release cycle the buffered redirect wins and new
  // jump/branch requests (including misaligned ones) are ignored.
  assign drain_pending = pend_valid_q && !stall;

  assign take_exc = exception || (misaligned && !drain_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      epc_q         <= 32'h0;
      flush_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_jump_q   <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      flush_q       <= flush_d;
      pend_valid_q  <= pend_valid_d;
      pend_jump_q   <= pend_jump_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    flush_d       = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_jump_d   = pend_jump_q;
    pend_target_d = pend_target_q;

    unique case (state_q)
      ST_BOOT: begin
        // One cycle at RESET_VECTOR; every request is ignored.
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (take_exc) begin
          // Exception entry is applied even while stalled.
          pc_d          = EXC_VECTOR;
          epc_d         = pc_q;
          flush_d       = 1'b1;
          pend_valid_d  = 1'b0;
          pend_jump_d   = 1'b0;
          pend_target_d = 32'h0;
        end else if (!stall) begin
          if (pend_valid_q) begin
            pc_d          = pend_target_q;
            flush_d       = 1'b1;
            pend_valid_d  = 1'b0;
            pend_jump_d   = 1'b0;
            pend_target_d = 32'h0;
          end else if (jump) begin
            pc_d    = jump_target;
            flush_d = 1'b1;
          end else if (branch_taken) begin
            pc_d    = branch_target;
            flush_d = 1'b1;
          end else if (halt) begin
            pc_d    = pc_plus4;
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end else begin
          // Stalled: pc holds. A buffered redirect is only replaced by a
          // strictly higher-priority one (jump over branch).
          if (jump && !(pend_valid_q && pend_jump_q)) begin
            pend_valid_d  = 1'b1;
            pend_jump_d   = 1'b1;
            pend_target_d = jump_target;
          end else if (!jump && branch_taken && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_jump_d   = 1'b0;
            pend_target_d = branch_target;
          end
        end
      end

      ST_HALT: begin
        if (exception) begin
          pc_d          = EXC_VECTOR;
          epc_d         = pc_q;
          flush_d       = 1'b1;
          pend_valid_d  = 1'b0;
          pend_jump_d   = 1'b0;
          pend_target_d = 32'h0;
          state_d       = ST_RUN;
        end else if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign pc               = pc_q;
  assign epc              = epc_q;
  assign flush            = flush_q;
  assign redirect_pending = pend_valid_q;
  assign state            = state_q;
  assign fetch_valid      = (state_q == ST_RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. pc_plus4 models the external
// incrementer; all expected values are hand-computed constants.

module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic [31:0] epc;
  logic        redirect_pending;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] S_BOOT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  pc_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_plus4         (pc_plus4),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .exception        (exception),
    .halt             (halt),
    .resume           (resume),
    .pc               (pc),
    .fetch_valid      (fetch_valid),
    .flush            (flush),
    .epc              (epc),
    .redirect_pending (redirect_pending),
    .state            (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external incrementer model
  assign pc_plus4 = pc + 32'd4;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    exception     = 1'b0;
    halt          = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_req();
    #12;
    chk("rst_pc",    pc, 32'h0);
    chk("rst_epc",   epc, 32'h0);
    chk("rst_state", {30'b0, state}, {30'b0, S_BOOT});
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_rp",    {31'b0, redirect_pending}, 32'h0);
    chk("rst_fv",    {31'b0, fetch_valid}, 32'h0);

    // 1. boot then sequential fetch
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_state", {30'b0, state}, {30'b0, S_BOOT});
    chk("boot_fv",    {31'b0, fetch_valid}, 32'h0);
    step();
    chk("run_state", {30'b0, state}, {30'b0, S_RUN});
    chk("run0_pc",   pc, 32'h0);
    chk("run0_fv",   {31'b0, fetch_valid}, 32'h1);
    step(); chk("run1_pc", pc, 32'h4);
    step(); chk("run2_pc", pc, 32'h8);
    step(); chk("run3_pc", pc, 32'hc);
    chk("run3_flush", {31'b0, flush}, 32'h0);
    step(); chk("run4_pc", pc, 32'h10);

    // 2. branch, then jump beating a simultaneous branch
    branch_taken = 1'b1; branch_target = 32'h40;
    step(); clear_req();
    chk("br_pc",    pc, 32'h40);
    chk("br_flush", {31'b0, flush}, 32'h1);
    step();
    chk("br_next_pc",    pc, 32'h44);
    chk("br_next_flush", {31'b0, flush}, 32'h0);
    jump = 1'b1; jump_target = 32'h100;
    branch_taken = 1'b1; branch_target = 32'h40;
    step(); clear_req();
    chk("jprio_pc",    pc, 32'h100);
    chk("jprio_flush", {31'b0, flush}, 32'h1);

    // 3. redirects during a 3-cycle stall at 0x20
    jump = 1'b1; jump_target = 32'h20;
    step(); clear_req();
    chk("to20_pc", pc, 32'h20);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    step();
    chk("st1_pc", pc, 32'h20);
    chk("st1_rp", {31'b0, redirect_pending}, 32'h1);
    chk("st1_fv", {31'b0, fetch_valid}, 32'h0);
    branch_taken = 1'b0; jump = 1'b1; jump_target = 32'h200;
    step();
    chk("st2_pc", pc, 32'h20);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    chk("st3_pc", pc, 32'h20);
    chk("st3_rp", {31'b0, redirect_pending}, 32'h1);
    clear_req();
    step();
    chk("rel_pc",    pc, 32'h200);
    chk("rel_flush", {31'b0, flush}, 32'h1);
    chk("rel_rp",    {31'b0, redirect_pending}, 32'h0);
    step();
    chk("rel_next_pc",    pc, 32'h204);
    chk("rel_next_flush", {31'b0, flush}, 32'h0);

    // 4. misaligned jump, then exception during stall
    jump = 1'b1; jump_target = 32'h44;
    step(); clear_req();
    chk("to44_pc", pc, 32'h44);
    jump = 1'b1; jump_target = 32'h102;
    step(); clear_req();
    chk("mis_pc",    pc, 32'h80);
    chk("mis_epc",   epc, 32'h44);
    chk("mis_flush", {31'b0, flush}, 32'h1);
    step(); step(); step(); step();
    chk("to90_pc", pc, 32'h90);
    stall = 1'b1; exception = 1'b1;
    step(); clear_req();
    chk("exc_pc",  pc, 32'h80);
    chk("exc_epc", epc, 32'h90);
    step();
    chk("exc_next_pc", pc, 32'h84);

    // 5. halt / resume
    jump = 1'b1; jump_target = 32'h30;
    step(); clear_req();
    halt = 1'b1;
    step(); clear_req();
    chk("halt_pc",    pc, 32'h34);
    chk("halt_state", {30'b0, state}, {30'b0, S_HALT});
    for (int i = 0; i < 5; i++) begin
      chk("halt_hold_pc", pc, 32'h34);
      chk("halt_hold_fv", {31'b0, fetch_valid}, 32'h0);
      step();
    end
    resume = 1'b1;
    step(); clear_req();
    chk("resume_state", {30'b0, state}, {30'b0, S_RUN});
    chk("resume_pc",    pc, 32'h34);
    step();
    chk("resume_next_pc", pc, 32'h38);

    // exception beats resume in HALT
    halt = 1'b1;
    step(); clear_req();
    chk("halt2_pc", pc, 32'h3c);
    exception = 1'b1; resume = 1'b1;
    step(); clear_req();
    chk("hexc_pc",    pc, 32'h80);
    chk("hexc_epc",   epc, 32'h3c);
    chk("hexc_state", {30'b0, state}, {30'b0, S_RUN});

    // halt while stalled is ignored
    stall = 1'b1; halt = 1'b1;
    step(); clear_req();
    chk("shalt_state", {30'b0, state}, {30'b0, S_RUN});
    chk("shalt_pc",    pc, 32'h80);

    // wrap-around
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step(); clear_req();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc",    pc, 32'h0);
    chk("wrap_flush", {31'b0, flush}, 32'h0);
    step(); step();
    chk("pre_rst_pc", pc, 32'h8);

    // 6. async reset mid-stall with a pending jump
    stall = 1'b1; jump = 1'b1; jump_target = 32'h500;
    step();
    chk("prst_rp", {31'b0, redirect_pending}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pc",    pc, 32'h0);
    chk("arst_rp",    {31'b0, redirect_pending}, 32'h0);
    chk("arst_state", {30'b0, state}, {30'b0, S_BOOT});
    clear_req();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
